keypad_ctrl: RTL and testbench
==============================

# keypad_ctrl

Controller for the 4x4 matrix keypad. It drives the row strobes at a divided scan rate, decodes the active-low column returns into 4-bit key codes, and debounces both press and release. Each accepted keystroke is queued in a small FIFO and presented to downstream logic through a valid/ready handshake. It sits between the keypad pins and the display/accumulator logic, and replaces free-running per-clock scanning.

## Interface
- SCAN_DIV, 1000: clk cycles per row step; one "tick" per step; >=2
- DEB_CNT, 20: consecutive identical tick samples needed to accept a press or a release; >=1
- FIFO_DEPTH, 4: key queue depth; power of 2, >=2
- REPEAT_DLY, 50: ticks held before first auto-repeat (only with macro)
- REPEAT_PER, 10: ticks between subsequent repeats (only with macro)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- SWC  in  4  column returns, active-low
- SWR  out  4  row drive, one row low at a time
- key_code  out  4  code at FIFO head
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts head when key_valid && key_ready
- overflow  out  1  sticky; a push was dropped

## Operation
- Row index r is 0..3 for SWR 1110, 1101, 1011, 0111. Column c is 0..3 for SWC 1110, 1101, 1011, 0111. Code = 4*r + c.
- SWC with zero bits or two or more bits low is treated as "no key". 1111 is "released".
- Divider counts 0..SCAN_DIV-1. A tick is asserted on the cycle it equals SCAN_DIV-1. SWC is sampled only on ticks.
- FSM:
  - SCAN: rows rotate on every tick, after the sample. A valid single-key sample loads the candidate code and count=1, freezes the rows, and moves to DEBOUNCE.
  - DEBOUNCE: on each tick, the same code increments count. A different or absent key returns to SCAN, and the rows resume rotation from the next row. When count reaches DEB_CNT, push the code, clear count, and go to HELD. With DEB_CNT=1 the push happens on the detecting tick and DEBOUNCE is skipped.
  - HELD: rows stay frozen. On each tick, 1111 increments the release count and anything else clears it. When the release count reaches DEB_CNT, go to SCAN. A second key pressed while held is ignored.
- FIFO:
  - Push when not full.
  - Push while full and without a pop in the same cycle: drop the code and set overflow.
  - Push and pop in the same cycle when full: both succeed and overflow stays 0.
  - Pop and push in the same cycle when empty: the push succeeds and the pop is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow is cleared only by rst.

## Timing
- Reset values: SWR=1110, key_code=0, key_valid=0, overflow=0, FSM=SCAN, divider=0, FIFO empty.
- rst mid-debounce or mid-held discards the candidate. Queued codes are lost.
- Let T0 be the first detecting tick. The push occurs at T0+(DEB_CNT-1)*SCAN_DIV cycles. key_valid and key_code update on the following cycle.
- key_code is stable while key_valid=1 and no pop occurs. After a pop, the next head appears on the next cycle.
- Row change takes effect the cycle after the tick, so each row is driven for SCAN_DIV cycles before it is sampled.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, after REPEAT_DLY ticks of the same key, push the code again.
  - Then push again every REPEAT_PER ticks until the release debounce begins.
  - Repeat pushes obey the overflow rules.
- KEYPAD_REPEAT_EN undefined: exactly one push per press. The REPEAT_* parameters are unused.

## Structure
- keypad_pkg holds:
  - FSM state enum (SCAN, DEBOUNCE, HELD)
  - key code typedef (4 bits)
  - row strobe constants ROW0..ROW3
  - the "no key" column constant 4'b1111
  - a column-decode function returning valid + index
- Sub-module keypad_fifo: parameterised synchronous FIFO with push/pop/full/empty/head.

## Test plan
Settings: SCAN_DIV=4, DEB_CNT=3, FIFO_DEPTH=4.
- After reset, no key: SWR cycles 1110, 1101, 1011, 0111, 1110 at 4-clk spacing; key_valid=0.
- Hold SWC=1011 while SWR=1101 (code 6), key_ready=1: exactly one key_code=6 pulse on key_valid, 1 cycle after the 3rd tick; SWR frozen at 1101 until 3 released ticks.
- Bounce: SWC=1110 for 2 ticks, then 1111, then stable: no push until 3 consecutive matching ticks.
- key_ready=0 with 5 distinct presses: FIFO holds first 4 in order and overflow=1. Raise key_ready: codes drain one per cycle.
- Two columns low (SWC=1100) on any row: no push, scanning continues.
- rst asserted mid-DEBOUNCE: outputs return to reset values immediately with no push. With KEYPAD_REPEAT_EN, REPEAT_DLY=2 and REPEAT_PER=1, a held key yields repeated codes.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, row/column constants and column decoding for the 4x4 keypad controller.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_e;

   typedef logic [3:0] key_code_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } col_dec_t;

   localparam logic [3:0] ROW0   = 4'b1110;
   localparam logic [3:0] ROW1   = 4'b1101;
   localparam logic [3:0] ROW2   = 4'b1011;
   localparam logic [3:0] ROW3   = 4'b0111;
   localparam logic [3:0] NO_KEY = 4'b1111;

   // Exactly one low column is a key; anything else (none or several) is rejected.
   function automatic col_dec_t decodeCol(input logic [3:0] swc);
      col_dec_t res;
      res.valid = 1'b1;
      res.idx   = 2'd0;
      case (swc)
         4'b1110: res.idx = 2'd0;
         4'b1101: res.idx = 2'd1;
         4'b1011: res.idx = 2'd2;
         4'b0111: res.idx = 2'd3;
         default: res.valid = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] rowStrobe(input logic [1:0] row);
      logic [3:0] strobe;
      case (row)
         2'd0:    strobe = ROW0;
         2'd1:    strobe = ROW1;
         2'd2:    strobe = ROW2;
         default: strobe = ROW3;
      endcase
      return strobe;
   endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small synchronous key queue; a push into a full queue is accepted only when a pop frees a slot.
module keypad_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign doPush  = push_i && (!full_o || pop_i);
   assign doPop   = pop_i && !empty_o;
   assign drop_o  = push_i && full_o && !pop_i;
   assign head_o  = mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/keypad_ctrl.sv
// 4x4 keypad scanner with tick-based press/release debounce and a key FIFO.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_CNT    = 20,
   parameter int FIFO_DEPTH = 4
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int REPEAT_DLY = 50,
   parameter int REPEAT_PER = 10
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] SWC,
   output logic [3:0] SWR,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEB_CNT + 1);

   state_e         state_q, state_d;
   logic [DW-1:0]  div_q, div_d;
   logic [1:0]     row_q, row_d;
   key_code_t      cand_q, cand_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  rel_q, rel_d;
   logic           ovf_q;

   logic           tick;
   col_dec_t       colDec;
   key_code_t      sampleCode;
   logic           sameKey;
   logic           debDone;
   logic           relDone;
   logic           repHit;
   logic           push;
   key_code_t      pushCode;
   logic           pop;
   key_code_t      fifoHead;
   logic           fifoFull;
   logic           fifoEmpty;
   logic           fifoDrop;

   assign tick       = (div_q == DW'(SCAN_DIV - 1));
   assign div_d      = tick ? '0 : div_q + DW'(1);
   assign colDec     = decodeCol(SWC);
   assign sampleCode = {row_q, colDec.idx};
   assign sameKey    = colDec.valid && (sampleCode == cand_q);
   assign debDone    = ((cnt_q + CW'(1)) == CW'(DEB_CNT));
   assign relDone    = ((rel_q + CW'(1)) == CW'(DEB_CNT));

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RW      = $clog2(REP_MAX + 1);

   logic [RW-1:0] rep_q, rep_d;
   logic          first_q, first_d;
   logic [RW-1:0] repTarget;

   // The first repeat waits the long delay, later ones the short period.
   assign repTarget = first_q ? RW'(REPEAT_DLY) : RW'(REPEAT_PER);
   assign repHit    = sameKey && ((rep_q + RW'(1)) == repTarget);

   always_comb begin
      rep_d   = rep_q;
      first_d = first_q;
      if (tick) begin
         if (state_q != HELD) begin
            rep_d   = '0;
            first_d = 1'b1;
         end else if (repHit) begin
            rep_d   = '0;
            first_d = 1'b0;
         end else if (sameKey) begin
            rep_d = rep_q + RW'(1);
         end else begin
            rep_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_q   <= '0;
         first_q <= 1'b1;
      end else begin
         rep_q   <= rep_d;
         first_q <= first_d;
      end
   end
`else
   assign repHit = 1'b0;
`endif

   // State register together with the scan/debounce datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SCAN;
         div_q   <= '0;
         row_q   <= 2'd0;
         cand_q  <= '0;
         cnt_q   <= '0;
         rel_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         row_q   <= row_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
         if (fifoDrop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Next-state logic; everything advances only on scan ticks.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      rel_d   = rel_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (colDec.valid) begin
                  cand_d = sampleCode;
                  rel_d  = '0;
                  if (DEB_CNT == 1) begin
                     cnt_d   = '0;
                     state_d = HELD;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = DEBOUNCE;
                  end
               end else begin
                  row_d = row_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (!sameKey) begin
                  cnt_d   = '0;
                  row_d   = row_q + 2'd1;
                  state_d = SCAN;
               end else if (debDone) begin
                  cnt_d   = '0;
                  rel_d   = '0;
                  state_d = HELD;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            HELD: begin
               if (SWC != NO_KEY) begin
                  rel_d = '0;
               end else if (relDone) begin
                  rel_d   = '0;
                  row_d   = row_q + 2'd1;
                  state_d = SCAN;
               end else begin
                  rel_d = rel_q + CW'(1);
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   // Outputs: row strobe and the FIFO push request.
   always_comb begin
      SWR      = rowStrobe(row_q);
      push     = 1'b0;
      pushCode = cand_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (DEB_CNT == 1 && colDec.valid) begin
                  push     = 1'b1;
                  pushCode = sampleCode;
               end
            end
            DEBOUNCE: push = sameKey && debDone;
            HELD:     push = repHit;
            default:  push = 1'b0;
         endcase
      end
   end

   assign pop       = key_valid && key_ready;
   assign key_valid = !fifoEmpty;
   assign key_code  = fifoEmpty ? 4'd0 : fifoHead;
   assign overflow  = ovf_q;

   keypad_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (pushCode),
      .head_o  (fifoHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .drop_o  (fifoDrop)
   );

   logic unusedFull;
   assign unusedFull = fifoFull;

endmodule

// File: tb/tb_keypad_ctrl.sv
// Directed bench for keypad_ctrl with SCAN_DIV=4, DEB_CNT=3, FIFO_DEPTH=4.
// A simple keypad model pulls one column low while its row is strobed.
module tb_keypad_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] SWC;
   logic [3:0] SWR;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready = 1'b0;
   logic       overflow;

   logic       keyDown = 1'b0;
   logic [1:0] keyRow = 2'd0;
   logic [1:0] keyCol = 2'd0;
   logic       ovrEn = 1'b0;
   logic [3:0] ovrVal = 4'hF;
   logic [3:0] modelSwc;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   function automatic logic [3:0] pat(input logic [1:0] i);
      case (i)
         2'd0:    return 4'b1110;
         2'd1:    return 4'b1101;
         2'd2:    return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   always_comb begin
      modelSwc = 4'hF;
      if (keyDown && SWR == pat(keyRow)) begin
         modelSwc = pat(keyCol);
      end
   end
   assign SWC = ovrEn ? ovrVal : modelSwc;

   keypad_ctrl #(
      .SCAN_DIV   (4),
      .DEB_CNT    (3),
      .FIFO_DEPTH (4)
`ifdef KEYPAD_REPEAT_EN
      ,
      .REPEAT_DLY (2),
      .REPEAT_PER (1)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .SWC       (SWC),
      .SWR       (SWR),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .overflow  (overflow)
   );

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic stepN(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pressKey(input logic [1:0] r, input logic [1:0] c);
      keyRow  = r;
      keyCol  = c;
      keyDown = 1'b1;
      stepN(40);
      keyDown = 1'b0;
      stepN(40);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (SWR !== 4'b1110) $display("[TB] FAIL reset_swr: got %b expected 1110", SWR); else passed++;
      checks++; if (key_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); else passed++;
      checks++; if (key_code !== 4'd0) $display("[TB] FAIL reset_code: got %0d expected 0", key_code); else passed++;
      checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else passed++;
   endtask

   task automatic test_scan_rotation();
      logic [3:0] exp;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp = pat(2'(i));
         checks++; if (SWR !== exp) $display("[TB] FAIL scan_row%0d: got %b expected %b", i, SWR, exp); else passed++;
         checks++; if (key_valid !== 1'b0) $display("[TB] FAIL scan_valid%0d: got %b expected 0", i, key_valid); else passed++;
         if (i < 4) stepN(4);
      end
   endtask

   task automatic test_single_key();
      int n;
      int k;
      int pulses;
      key_ready = 1'b1;
      keyRow = 2'd1;
      keyCol = 2'd2;
      keyDown = 1'b1;
      n = 0;
      while (SWR !== 4'b1101 && n < 20) begin
         stepN(1);
         n++;
      end
      checks++; if (n != 4) $display("[TB] FAIL single_row_entry: got %0d cycles expected 4", n); else passed++;
      k = 0;
      while (key_valid !== 1'b1 && k < 30) begin
         stepN(1);
         k++;
      end
      checks++; if (k != 12) $display("[TB] FAIL single_latency: got %0d cycles expected 12", k); else passed++;
      checks++; if (key_code !== 4'd6) $display("[TB] FAIL single_code: got %0d expected 6", key_code); else passed++;
      pulses = (key_valid === 1'b1) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         stepN(1);
         if (key_valid === 1'b1) pulses++;
      end
      checks++; if (SWR !== 4'b1101) $display("[TB] FAIL single_frozen: got %b expected 1101", SWR); else passed++;
      keyDown = 1'b0;
      for (int i = 0; i < 8; i++) begin
         stepN(1);
         if (key_valid === 1'b1) pulses++;
      end
      checks++; if (SWR !== 4'b1101) $display("[TB] FAIL single_release_frozen: got %b expected 1101", SWR); else passed++;
      for (int i = 0; i < 8; i++) begin
         stepN(1);
         if (key_valid === 1'b1) pulses++;
      end
      checks++; if (SWR === 4'b1101) $display("[TB] FAIL single_resume: got %b expected not 1101", SWR); else passed++;
      checks++; if (pulses != 1) $display("[TB] FAIL single_pulses: got %0d expected 1", pulses); else passed++;
      key_ready = 1'b0;
   endtask

   task automatic test_bounce();
      logic [3:0] seq [6];
      logic       expValid;
      seq[0] = 4'b1110; seq[1] = 4'b1110; seq[2] = 4'b1111;
      seq[3] = 4'b1110; seq[4] = 4'b1110; seq[5] = 4'b1110;
      key_ready = 1'b0;
      keyDown = 1'b0;
      ovrEn = 1'b1;
      ovrVal = 4'hF;
      resetDut();
      for (int t = 0; t < 6; t++) begin
         ovrVal = seq[t];
         stepN(4);
         expValid = (t == 5);
         checks++; if (key_valid !== expValid) $display("[TB] FAIL bounce_valid_t%0d: got %b expected %b", t, key_valid, expValid); else passed++;
      end
      checks++; if (key_code !== 4'd4) $display("[TB] FAIL bounce_code: got %0d expected 4", key_code); else passed++;
      ovrVal = 4'hF;
      stepN(16);
      ovrEn = 1'b0;
   endtask

   task automatic test_overflow();
      logic [3:0] exp [4];
      exp[0] = 4'd1; exp[1] = 4'd6; exp[2] = 4'd11; exp[3] = 4'd12;
      key_ready = 1'b0;
      resetDut();
      pressKey(2'd0, 2'd1);
      pressKey(2'd1, 2'd2);
      pressKey(2'd2, 2'd3);
      pressKey(2'd3, 2'd0);
      checks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_before: got %b expected 0", overflow); else passed++;
      pressKey(2'd2, 2'd1);
      checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_after: got %b expected 1", overflow); else passed++;
      key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (key_valid !== 1'b1 || key_code !== exp[i]) $display("[TB] FAIL ovf_drain%0d: got valid=%b code=%0d expected valid=1 code=%0d", i, key_valid, key_code, exp[i]); else passed++;
         stepN(1);
      end
      checks++; if (key_valid !== 1'b0) $display("[TB] FAIL ovf_empty: got %b expected 0", key_valid); else passed++;
      checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); else passed++;
      key_ready = 1'b0;
   endtask

   task automatic test_full_push_pop();
      logic [3:0] exp [4];
      int n;
      exp[0] = 4'd6; exp[1] = 4'd11; exp[2] = 4'd12; exp[3] = 4'd15;
      key_ready = 1'b0;
      resetDut();
      pressKey(2'd0, 2'd1);
      pressKey(2'd1, 2'd2);
      pressKey(2'd2, 2'd3);
      pressKey(2'd3, 2'd0);
      n = 0;
      while (SWR !== 4'b0111 && n < 20) begin stepN(1); n++; end
      while (SWR === 4'b0111 && n < 40) begin stepN(1); n++; end
      keyRow = 2'd3;
      keyCol = 2'd3;
      keyDown = 1'b1;
      while (SWR !== 4'b0111 && n < 60) begin stepN(1); n++; end
      checks++; if (n >= 60) $display("[TB] FAIL fpp_align: got timeout expected row 0111"); else passed++;
      stepN(11);
      key_ready = 1'b1;
      stepN(1);
      key_ready = 1'b0;
      checks++; if (overflow !== 1'b0) $display("[TB] FAIL fpp_overflow: got %b expected 0", overflow); else passed++;
      checks++; if (key_code !== 4'd6) $display("[TB] FAIL fpp_head: got %0d expected 6", key_code); else passed++;
      keyDown = 1'b0;
      stepN(40);
      key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (key_valid !== 1'b1 || key_code !== exp[i]) $display("[TB] FAIL fpp_drain%0d: got valid=%b code=%0d expected valid=1 code=%0d", i, key_valid, key_code, exp[i]); else passed++;
         stepN(1);
      end
      checks++; if (key_valid !== 1'b0) $display("[TB] FAIL fpp_empty: got %b expected 0", key_valid); else passed++;
      key_ready = 1'b0;
   endtask

`ifdef KEYPAD_REPEAT_EN
   task automatic test_repeat();
      int pulses;
      int badCode;
      key_ready = 1'b1;
      resetDut();
      keyRow = 2'd0;
      keyCol = 2'd0;
      keyDown = 1'b1;
      pulses = 0;
      badCode = 0;
      for (int i = 0; i < 80; i++) begin
         stepN(1);
         if (key_valid === 1'b1) begin
            pulses++;
            if (key_code !== 4'd0) badCode++;
         end
      end
      checks++; if (pulses < 5) $display("[TB] FAIL repeat_pulses: got %0d expected at least 5", pulses); else passed++;
      checks++; if (badCode != 0) $display("[TB] FAIL repeat_code: got %0d wrong codes expected 0", badCode); else passed++;
      keyDown = 1'b0;
      stepN(40);
      key_ready = 1'b0;
   endtask
`endif

   task automatic test_two_cols();
      logic [3:0] prev;
      int changes;
      int sawValid;
      key_ready = 1'b0;
      keyDown = 1'b0;
      ovrEn = 1'b1;
      ovrVal = 4'b1100;
      resetDut();
      prev = SWR;
      changes = 0;
      sawValid = 0;
      for (int i = 0; i < 40; i++) begin
         stepN(1);
         if (SWR !== prev) changes++;
         prev = SWR;
         if (key_valid === 1'b1) sawValid++;
      end
      checks++; if (changes != 10) $display("[TB] FAIL twocol_rotation: got %0d row changes expected 10", changes); else passed++;
      checks++; if (sawValid != 0) $display("[TB] FAIL twocol_valid: got %0d valid cycles expected 0", sawValid); else passed++;
      ovrEn = 1'b0;
   endtask

   task automatic test_reset_mid_debounce();
      key_ready = 1'b0;
      keyDown = 1'b0;
      ovrEn = 1'b1;
      ovrVal = 4'hF;
      resetDut();
      stepN(8);
      ovrVal = 4'b0111;
      stepN(8);
      checks++; if (SWR !== 4'b1011) $display("[TB] FAIL rstdeb_frozen: got %b expected 1011", SWR); else passed++;
      stepN(1);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (SWR !== 4'b1110) $display("[TB] FAIL rstdeb_swr: got %b expected 1110", SWR); else passed++;
      checks++; if (key_valid !== 1'b0) $display("[TB] FAIL rstdeb_valid: got %b expected 0", key_valid); else passed++;
      checks++; if (key_code !== 4'd0) $display("[TB] FAIL rstdeb_code: got %0d expected 0", key_code); else passed++;
      checks++; if (overflow !== 1'b0) $display("[TB] FAIL rstdeb_overflow: got %b expected 0", overflow); else passed++;
      ovrVal = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      stepN(30);
      checks++; if (key_valid !== 1'b0) $display("[TB] FAIL rstdeb_nopush: got %b expected 0", key_valid); else passed++;
      ovrEn = 1'b0;
   endtask

   initial begin
      $display("[TB] keypad_ctrl bench start");
      test_reset();
      test_scan_rotation();
`ifdef KEYPAD_REPEAT_EN
      test_repeat();
`else
      test_single_key();
      test_bounce();
      test_overflow();
      test_full_push_pop();
`endif
      test_two_cols();
      test_reset_mid_debounce();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
